multicycle_controller: RTL and testbench

- FSM-based main controller for a multicycle RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Shares a single memory port with a req/ack handshake and has a bounded ack timeout.
- Drives the existing datapath control encoding (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch, JalrSel, RWSel), adds AUIPC, and traps on illegal opcodes or bus timeout.

---
 rtl/multicycle_controller.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM for a multicycle RV32I datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB over one shared req/ack memory port,
// traps on illegal opcodes or an unanswered memory request.
// Optional feature: define MULTICYCLE_CTRL_INSTRET_EN to add the instret
// retired-instruction counter (and its CNT_W parameter).
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             stall,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             ir_write,
    output logic             pc_update,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       ALUOp,
    output logic             Branch,
    output logic             JalrSel,
    output logic [1:0]       RWSel,
    output logic             illegal_instr,
    output logic             bus_err,
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    output logic [CNT_W-1:0] instret,
`endif
    output logic             busy
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Last counted wait cycle; an ack arriving in it still completes.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_nxt;
    logic [6:0] opc;
    logic [7:0] to_cnt, to_cnt_nxt;
    logic       ctrl_en, set_ill, set_berr, opc_legal;
    logic       is_r, is_lw, is_sw, is_i, is_br, is_jal, is_jalr, is_lui, is_auipc;

    assign is_r     = (opc == OP_R);
    assign is_lw    = (opc == OP_LW);
    assign is_sw    = (opc == OP_SW);
    assign is_i     = (opc == OP_I);
    assign is_br    = (opc == OP_BR);
    assign is_jal   = (opc == OP_JAL);
    assign is_jalr  = (opc == OP_JALR);
    assign is_lui   = (opc == OP_LUI);
    assign is_auipc = (opc == OP_AUIPC);

    // Legality of the live IR opcode, used for the DECODE branch
    always_comb begin
        case (Opcode)
            OP_R, OP_LW, OP_SW, OP_I, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opc_legal = 1'b1;
            default:                           opc_legal = 1'b0;
        endcase
    end

    // Next-state and handshake/strobe outputs
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        ir_write  = 1'b0;
        pc_update = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ctrl_en   = 1'b0;
        set_ill   = 1'b0;
        set_berr  = 1'b0;
        case (state)
            FETCH: begin
                // A request already outstanding (counter running) ignores stall.
                // Gating with reset keeps the port quiet while reset is held.
                mem_req = reset & (~stall | (to_cnt != 8'd0));
                if (mem_req && mem_ack) begin
                    ir_write  = 1'b1;
                    state_nxt = DECODE;
                end else if (mem_req && to_cnt == TO_LAST) begin
                    set_berr  = 1'b1;
                    state_nxt = TRAP;
                end
            end
            DECODE: begin
                if (opc_legal) begin
                    state_nxt = EXEC;
                end else begin
                    set_ill   = 1'b1;
                    state_nxt = TRAP;
                end
            end
            EXEC: begin
                ctrl_en = 1'b1;
                if (is_lw || is_sw) begin
                    state_nxt = MEM;
                end else if (is_br) begin
                    pc_update = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                ctrl_en  = 1'b1;
                mem_req  = 1'b1;
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (mem_ack) begin
                    if (is_lw) begin
                        state_nxt = WB;
                    end else begin
                        pc_update = 1'b1;
                        state_nxt = FETCH;
                    end
                end else if (to_cnt == TO_LAST) begin
                    set_berr  = 1'b1;
                    state_nxt = TRAP;
                end
            end
            WB: begin
                ctrl_en   = 1'b1;
                RegWrite  = 1'b1;
                pc_update = 1'b1;
                state_nxt = FETCH;
            end
            TRAP: begin
                state_nxt = TRAP;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Wait counter: cleared on every state change, counts unanswered req cycles
    always_comb begin
        to_cnt_nxt = to_cnt;
        if (state_nxt != state) begin
            to_cnt_nxt = 8'd0;
        end else if (mem_req && !mem_ack) begin
            to_cnt_nxt = to_cnt + 8'd1;
        end
    end

    // State, latched opcode and wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            opc    <= 7'd0;
            to_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            if (state == DECODE) begin
                opc <= Opcode;
            end
        end
    end

    // Sticky trap causes, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_instr <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            illegal_instr <= illegal_instr | set_ill;
            bus_err       <= bus_err | set_berr;
        end
    end

    // Datapath control decode from the latched opcode, live in EXEC/MEM/WB
    assign ALUSrc   = ctrl_en & (is_lw | is_sw | is_i | is_jalr | is_auipc);
    assign MemtoReg = ctrl_en & is_lw;
    assign ALUOp    = ctrl_en ? {is_r | is_i | is_jal | is_lui, is_br | is_jal | is_lui} : 2'b00;
    assign Branch   = ctrl_en & (is_br | is_jal);
    assign JalrSel  = ctrl_en & is_jalr;
    assign RWSel    = ctrl_en ? {is_lui | is_auipc, is_jal | is_jalr | is_auipc} : 2'b00;

    assign busy = (state != TRAP) && !(state == FETCH && !mem_req);

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    // Retired-instruction count, one per committed PC; wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret <= '0;
        end else if (pc_update) begin
            instret <= instret + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized self-checking bench. A transaction
// model predicts cycle counts, strobe counts and control signatures per
// instruction from the opcode class and the memory ack delays.
module tb_multicycle_controller;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] Opcode = 7'd0;
    logic       stall = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, ir_write, pc_update, ALUSrc, MemtoReg, RegWrite;
    logic       MemRead, MemWrite, Branch, JalrSel, illegal_instr, bus_err, busy;
    logic [1:0] ALUOp, RWSel;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [CW-1:0] instret;
`endif
    logic [7:0] ctrl;

    assign ctrl = {ALUSrc, MemtoReg, ALUOp, Branch, JalrSel, RWSel};

    multicycle_controller #(
        .TIMEOUT_CYCLES(TO)
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .stall(stall), .mem_ack(mem_ack),
        .mem_req(mem_req), .ir_write(ir_write), .pc_update(pc_update),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .Branch(Branch),
        .JalrSel(JalrSel), .RWSel(RWSel), .illegal_instr(illegal_instr),
        .bus_err(bus_err),
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        .instret(instret),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_ret = 0;

    logic [6:0] legal [9] = '{OP_R, OP_LW, OP_SW, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    // per-run observations
    int         o_cyc, o_req, o_rd, o_wr, o_rw, o_pcu, o_irw_at, o_bad, o_idle;
    bit         o_rwlast, o_ill, o_berr;
    logic [7:0] o_ctrl_last, o_ctrl_first;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // {ALUSrc, MemtoReg, ALUOp, Branch, JalrSel, RWSel} for each instruction
    function automatic logic [7:0] exp_ctrl(input logic [6:0] op);
        case (op)
            OP_R:     return 8'b0_0_10_0_0_00;
            OP_LW:    return 8'b1_1_00_0_0_00;
            OP_SW:    return 8'b1_0_00_0_0_00;
            OP_I:     return 8'b1_0_10_0_0_00;
            OP_BR:    return 8'b0_0_01_1_0_00;
            OP_JAL:   return 8'b0_0_11_1_0_01;
            OP_JALR:  return 8'b1_0_00_0_1_01;
            OP_LUI:   return 8'b0_0_11_0_0_10;
            OP_AUIPC: return 8'b1_0_00_0_0_11;
            default:  return 8'h00;
        endcase
    endfunction

    // Drive one instruction: k stalled idle cycles, then memory answers the
    // fetch on its (df+1)th req cycle and the data access on its (dd+1)th.
    // Opcode carries garbage except in the DECODE cycle.
    task automatic run(input logic [6:0] opc, input int k, input int df, input int dd);
        int w = 0;
        bit seen_req = 0, prev_irw = 0, data_ph = 0, ack;
        o_cyc = 0; o_req = 0; o_rd = 0; o_wr = 0; o_rw = 0; o_pcu = 0;
        o_irw_at = -1; o_bad = 0; o_idle = 0; o_rwlast = 0;
        o_ctrl_last = 8'h00; o_ctrl_first = 8'hff;
        while (o_cyc < 60) begin
            @(negedge clk);
            if (o_cyc < k)      stall = 1'b1;
            else if (!seen_req) stall = 1'b0;
            else                stall = 1'($urandom);
            Opcode = prev_irw ? opc : 7'($urandom);
            #1;
            ack = 1'b0;
            if (mem_req) begin
                ack = (w == (data_ph ? dd : df));
                w++;
                seen_req = 1'b1;
            end
            mem_ack = ack;
            #1;
            o_cyc++;
            if (o_cyc == 1) o_ctrl_first = ctrl;
            o_req  += int'(mem_req);
            o_rd   += int'(MemRead);
            o_wr   += int'(MemWrite);
            o_rw   += int'(RegWrite);
            o_idle += int'(!busy);
            if (o_irw_at >= 0 && (o_cyc - 1) > o_irw_at + 1 && !illegal_instr && !bus_err
                && ctrl != exp_ctrl(opc)) o_bad++;
            if (ir_write) begin
                o_irw_at = o_cyc - 1;
                data_ph  = 1'b1;
                w        = 0;
            end
            prev_irw = ir_write;
            o_rwlast = RegWrite;
            if (pc_update) begin
                o_pcu++;
                o_ctrl_last = ctrl;
                break;
            end
            if (illegal_instr || bus_err) break;
        end
        o_ill  = illegal_instr;
        o_berr = bus_err;
    endtask

    task automatic check_instr(input logic [6:0] opc, input int k, input int df, input int dd);
        bit lw, sw, wb;
        int mc;
        lw = (opc == OP_LW);
        sw = (opc == OP_SW);
        wb = !(sw || opc == OP_BR);
        mc = (lw || sw) ? dd + 1 : 0;
        run(opc, k, df, dd);
        // stall + fetch wait + DECODE + EXEC + data wait + WB
        chk("cycles",    o_cyc, k + df + 3 + mc + int'(wb));
        chk("req_cyc",   o_req, df + 1 + mc);
        chk("ir_write",  o_irw_at, k + df);
        chk("memread",   o_rd, lw ? mc : 0);
        chk("memwrite",  o_wr, sw ? mc : 0);
        chk("regwrite",  o_rw, int'(wb));
        chk("rw_last",   o_rwlast, wb);
        chk("pc_update", o_pcu, 1);
        chk("ctrl",      o_ctrl_last, exp_ctrl(opc));
        chk("ctrl_held", o_bad, 0);
        chk("ctrl_fetch", o_ctrl_first, 8'h00);
        chk("idle",      o_idle, k);
        chk("no_trap",   {o_ill, o_berr}, 2'b00);
        n_ret++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        stall = 1'b0;
        mem_ack = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_req",   mem_req, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_flags", {illegal_instr, bus_err}, 2'b00);
        chk("rst_ctrl",  ctrl, 8'h00);
        chk("rst_strb",  {ir_write, pc_update, RegWrite, MemRead, MemWrite}, 5'd0);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        chk("rst_instret", instret, 0);
`endif
        n_ret = 0;
        @(negedge clk);
        stall = 1'b1;
        #1;
        reset = 1'b1;
    endtask

    task automatic check_instret();
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        @(posedge clk);
        #1;
        chk("instret", instret, n_ret % (1 << CW));
`endif
    endtask

    task automatic check_trap_hold(input bit ill, input bit berr);
        int reqs = 0, act = 0;
        repeat (3) begin
            @(negedge clk);
            stall = 1'($urandom);
            mem_ack = 1'($urandom);
            #1;
            reqs += int'(mem_req);
            act  += int'(busy) + int'(pc_update) + int'(RegWrite) + int'(ir_write);
        end
        chk("trap_req",   reqs, 0);
        chk("trap_quiet", act, 0);
        chk("trap_ctrl",  ctrl, 8'h00);
        chk("trap_flags", {illegal_instr, bus_err}, {ill, berr});
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        chk("trap_instret", instret, n_ret % (1 << CW));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // LW parked in MEM, then asynchronous reset mid-access
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            stall = 1'b0;
            Opcode = (i == 1) ? OP_LW : 7'($urandom);
            mem_ack = (i == 0);
        end
        #1;
        chk("mid_mem_rd",  MemRead, 1);
        chk("mid_mem_req", mem_req, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_req",  {mem_req, MemRead}, 2'b00);
        chk("async_busy", busy, 0);
        chk("async_ctrl", ctrl, 8'h00);
        stall = 1'b1;
        mem_ack = 1'b0;
        n_ret = 0;
        @(negedge clk);
        #1;
        reset = 1'b1;

        // stall for 5 cycles after reset, then three instructions
        check_instr(OP_R, 5, 0, 0);
        check_instr(OP_LW, 0, 1, 1);
        check_instr(OP_BR, 0, 0, 0);
        check_instret();

        // directed classes and delays; delay 3 acks on the last counted cycle
        check_instr(OP_R, 0, 0, 0);
        check_instr(OP_LW, 0, 3, 2);
        check_instr(OP_SW, 0, 1, 2);
        check_instr(OP_BR, 0, 2, 0);
        check_instr(OP_AUIPC, 0, 0, 0);
        check_instr(OP_LUI, 1, 1, 0);
        check_instr(OP_JAL, 0, 0, 0);
        check_instr(OP_JALR, 0, 2, 0);
        check_instr(OP_I, 0, 0, 0);
        check_instr(OP_LW, 0, 3, 3);
        check_instret();

        for (int n = 0; n < 40; n++) begin
            check_instr(legal[$urandom_range(0, 8)], $urandom_range(0, 2),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            if (n % 8 == 7) check_instret();
        end

        // illegal opcode
        run(7'b1111111, 0, 1, 0);
        chk("ill_cycles", o_cyc, 4);
        chk("ill_req",    o_req, 2);
        chk("ill_pcu",    o_pcu, 0);
        chk("ill_flags",  {o_ill, o_berr}, 2'b10);
        check_trap_hold(1'b1, 1'b0);
        do_reset();

        // fetch never acknowledged
        run(OP_R, 0, 99, 0);
        chk("fto_cycles", o_cyc, TO + 1);
        chk("fto_req",    o_req, TO);
        chk("fto_flags",  {o_ill, o_berr}, 2'b01);
        check_trap_hold(1'b0, 1'b1);
        do_reset();

        // data access never acknowledged
        check_instr(OP_R, 0, 0, 0);
        run(OP_LW, 0, 0, 99);
        chk("mto_cycles", o_cyc, 3 + TO + 1);
        chk("mto_req",    o_req, 1 + TO);
        chk("mto_rd",     o_rd, TO);
        chk("mto_rw",     o_rw, 0);
        chk("mto_flags",  {o_ill, o_berr}, 2'b01);
        check_trap_hold(1'b0, 1'b1);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
